// File: rtl/slice_seq_pkg.sv
// slice_seq_pkg: shared FSM type, default geometry and shift helper for slice_sequencer.
package slice_seq_pkg;
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, RUN} seq_state_e;
  localparam int DEF_SLICES = 128;
  localparam int DEF_COLUMNS = 8;
  localparam int DEF_PERIOD_W = 24;
  function automatic int shift_of(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/slice_sequencer_hall_filter.sv
// hall_filter: two-flop synchronizer and low-level debounce, one edge pulse per low phase.
module hall_filter #(
  parameter int DEBOUNCE = 16
) (
  input  logic clock_66,
  input  logic nrst,
  input  logic hall_n,
  output logic edge_pulse
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);
  logic [1:0] sync;
  logic [CW-1:0] low_cnt;
  logic armed;
  // armed is only set by a high level, so a long low phase yields one pulse
  always_ff @(posedge clock_66 or negedge nrst)
    if (!nrst) begin
      sync <= 2'b11;
      low_cnt <= '0;
      armed <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync <= {sync[0], hall_n};
      edge_pulse <= armed && !sync[1] && low_cnt == LAST;
      if (sync[1]) begin
        low_cnt <= '0;
        armed <= 1'b1;
      end else begin
        low_cnt <= low_cnt == LAST ? low_cnt : low_cnt + 1'b1;
        armed <= armed && low_cnt != LAST;
      end
    end
endmodule

// File: rtl/slice_sequencer.sv
// slice_sequencer: hall-locked turn timing, slice/column slot scheduling gated by driver_ready.
// Optional SLICE_SEQ_STATS_EN adds skip_cnt and short_cnt statistics outputs.
module slice_sequencer
  import slice_seq_pkg::*;
#(
  parameter int SLICES = DEF_SLICES,
  parameter int COLUMNS = DEF_COLUMNS,
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int MIN_PERIOD = 65536,
  parameter int MAX_PERIOD = 8_000_000,
  parameter int DEBOUNCE = 16
) (
  input  logic clock_66,
  input  logic nrst,
  input  logic hall_n,
  input  logic driver_ready,
  output logic position_sync,
  output logic column_ready,
  output logic [$clog2(SLICES)-1:0] slice_idx,
  output logic [$clog2(COLUMNS)-1:0] column_idx,
  output logic locked,
  output logic [PERIOD_W-1:0] period
`ifdef SLICE_SEQ_STATS_EN
  ,
  output logic [15:0] skip_cnt,
  output logic [7:0] short_cnt
`endif
);
  localparam int SW = $clog2(SLICES);
  localparam int CWI = $clog2(COLUMNS);
  localparam int SH = shift_of(SLICES) + shift_of(COLUMNS);
  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] MAX_P = PERIOD_W'(MAX_PERIOD);
  localparam logic [SW-1:0] LAST_S = SW'(SLICES - 1);
  localparam logic [CWI-1:0] LAST_C = CWI'(COLUMNS - 1);
  seq_state_e state;
  logic hall_edge, sat, short_turn, valid_turn, glitch, take, restart, expire;
  logic last_slice, last_slot, slot_start, done;
  logic [PERIOD_W-1:0] turn_cnt, len, col_len, timer;
  hall_filter #(.DEBOUNCE(DEBOUNCE)) u_filter (
    .clock_66(clock_66),
    .nrst(nrst),
    .hall_n(hall_n),
    .edge_pulse(hall_edge)
  );
  // len counts the edge cycle itself, so it equals the edge-to-edge distance
  assign len = turn_cnt + 1'b1;
  assign sat = turn_cnt == MAX_P;
  assign short_turn = len < MIN_P;
  assign valid_turn = !short_turn && len < MAX_P;
  assign glitch = hall_edge && state == RUN && short_turn;
  assign take = hall_edge && !glitch;
  assign restart = hall_edge && state != UNLOCKED && valid_turn;
  assign expire = state == RUN && !done && timer == '0;
  assign last_slice = slice_idx == LAST_S;
  assign last_slot = last_slice && column_idx == LAST_C;
  assign locked = state == RUN;
  assign column_ready = slot_start && driver_ready;
  always_ff @(posedge clock_66 or negedge nrst)
    if (!nrst) state <= UNLOCKED;
    else if (restart) state <= RUN;
    else if (hall_edge && state == UNLOCKED) state <= ACQUIRE;
    else if (sat) state <= UNLOCKED;
    else if (take) state <= short_turn ? ACQUIRE : UNLOCKED;
  always_ff @(posedge clock_66 or negedge nrst)
    if (!nrst) begin
      turn_cnt <= '0;
      period <= '0;
      col_len <= '0;
    end else begin
      turn_cnt <= take ? '0 : sat ? turn_cnt : turn_cnt + 1'b1;
      period <= restart ? len : period;
      col_len <= restart ? len >> SH : col_len;
    end
  // after the last slot the indices hold until the next edge absorbs the remainder
  always_ff @(posedge clock_66 or negedge nrst)
    if (!nrst) begin
      slice_idx <= '0;
      column_idx <= '0;
      timer <= '0;
      done <= 1'b0;
      slot_start <= 1'b0;
      position_sync <= 1'b0;
    end else if (restart) begin
      slice_idx <= '0;
      column_idx <= '0;
      timer <= (len >> SH) - 1'b1;
      done <= 1'b0;
      slot_start <= 1'b1;
      position_sync <= 1'b1;
    end else if (state != RUN || sat || take) begin
      slice_idx <= '0;
      column_idx <= '0;
      timer <= '0;
      done <= 1'b0;
      slot_start <= 1'b0;
      position_sync <= 1'b0;
    end else begin
      slot_start <= expire && !last_slot;
      position_sync <= expire && column_idx == LAST_C && !last_slice;
      if (expire) begin
        timer <= col_len - 1'b1;
        done <= last_slot;
        column_idx <= last_slot ? column_idx : column_idx + 1'b1;
        slice_idx <= (column_idx == LAST_C && !last_slice) ? slice_idx + 1'b1 : slice_idx;
      end else if (!done) timer <= timer - 1'b1;
    end
`ifdef SLICE_SEQ_STATS_EN
  always_ff @(posedge clock_66 or negedge nrst)
    if (!nrst) begin
      skip_cnt <= '0;
      short_cnt <= '0;
    end else begin
      skip_cnt <= take ? '0 : (slot_start && !driver_ready && skip_cnt != '1) ? skip_cnt + 1'b1 : skip_cnt;
      short_cnt <= (hall_edge && state != UNLOCKED && short_turn && short_cnt != '1) ? short_cnt + 1'b1 : short_cnt;
    end
`endif
endmodule

// File: tb/tb_slice_sequencer.sv
// tb_slice_sequencer: randomized hall/driver stimulus against an arithmetic slot-schedule model.
module tb_slice_sequencer;
  localparam int S = 8;
  localparam int C = 4;
  localparam int MINP = 512;
  localparam int MAXP = 3000;
  localparam int D = 16;
  localparam int SH = 5;
  localparam int LAT = D + 3;
  logic clock_66 = 1'b0;
  logic nrst = 1'b1;
  logic hall_n = 1'b1;
  logic driver_ready = 1'b1;
  logic position_sync, column_ready, locked;
  logic [2:0] slice_idx;
  logic [1:0] column_idx;
  logic [15:0] period;
  logic [23:0] got, want;
`ifdef SLICE_SEQ_STATS_EN
  logic [15:0] skip_cnt;
  logic [7:0] short_cnt;
`endif
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int ev[$];
  int lo_s[$];
  int lo_l[$];
  bit drh[100000];
  bit dr_rand;
  int dr_s, dr_e;

  slice_sequencer #(
    .SLICES(S), .COLUMNS(C), .PERIOD_W(16), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP), .DEBOUNCE(D)
  ) dut (
    .clock_66(clock_66),
    .nrst(nrst),
    .hall_n(hall_n),
    .driver_ready(driver_ready),
    .position_sync(position_sync),
    .column_ready(column_ready),
    .slice_idx(slice_idx),
    .column_idx(column_idx),
    .locked(locked),
    .period(period)
`ifdef SLICE_SEQ_STATS_EN
    ,
    .skip_cnt(skip_cnt),
    .short_cnt(short_cnt)
`endif
  );

  always #5 clock_66 = ~clock_66;
  always @(posedge clock_66) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d expired before end of sequence", cyc);
    $fatal(1);
  end

  // expected {locked, position_sync, column_ready, slice, column, period} in cycle t
  function automatic logic [23:0] expv(input int t);
    int i, p, cl, off, k;
    logic lk, ps, cr;
    logic [2:0] sl;
    logic [1:0] co;
    logic [15:0] per;
    i = -1;
    {lk, ps, cr, sl, co, per} = '0;
    foreach (ev[j]) if (ev[j] + LAT <= t) i = j;
    if (i >= 1) begin
      p = ev[i] - ev[i-1];
      cl = p >> SH;
      off = t - ev[i] - LAT;
      k = off / cl;
      lk = 1'b1;
      per = 16'(p);
      if (k < S * C) begin
        sl = 3'(k / C);
        co = 2'(k % C);
        ps = (off % cl == 0) && (k % C == 0);
        cr = (off % cl == 0) && drh[t];
      end else begin
        sl = 3'(S - 1);
        co = 2'(C - 1);
      end
    end
    return {lk, ps, cr, sl, co, per};
  endfunction

  task automatic step();
    @(posedge clock_66);
    #1;
    hall_n = 1'b1;
    foreach (lo_s[j]) if (cyc >= lo_s[j] && cyc < lo_s[j] + lo_l[j]) hall_n = 1'b0;
    driver_ready = dr_rand ? ($urandom_range(3) != 0) : !(cyc >= dr_s && cyc < dr_e);
    drh[cyc] = driver_ready;
    @(negedge clock_66);
    got = {locked, position_sync, column_ready, slice_idx, column_idx, period};
  endtask

  task automatic add_pulse(input int start, input int len, input bit counts);
    lo_s.push_back(start);
    lo_l.push_back(len);
    if (counts) ev.push_back(start);
  endtask

  task automatic reset_dut();
    @(posedge clock_66);
    #3 nrst = 1'b0;
    lo_s.delete();
    lo_l.delete();
    ev.delete();
    hall_n = 1'b1;
    driver_ready = 1'b1;
    dr_rand = 1'b0;
    dr_s = 0;
    dr_e = 0;
    repeat (3) @(posedge clock_66);
    #1 nrst = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    repeat (MAXP + 10) begin
      step();
      want = expv(cyc);
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL idle cyc=%0d got=%h want=%h", cyc, got, want); end
    end
  endtask

  task automatic test_lock();
    int t0, s1, nps, ncr;
    reset_dut();
    t0 = cyc + 20;
    for (int j = 0; j < 4; j++) add_pulse(t0 + j * 1024, 100, 1'b1);
    s1 = t0 + 1024 + LAT;
    nps = 0;
    ncr = 0;
    while (cyc < t0 + 3 * 1024 + LAT + 100) begin
      step();
      want = expv(cyc);
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL lock cyc=%0d got=%h want=%h", cyc, got, want); end
      if (cyc >= s1 && cyc < s1 + 2048) begin nps += int'(position_sync); ncr += int'(column_ready); end
    end
    n_chk++;
    if (nps != 2 * S || ncr != 2 * S * C) begin
      n_fail++;
      $display("FAIL lock_counts got ps=%0d cr=%0d want ps=%0d cr=%0d", nps, ncr, 2 * S, 2 * S * C);
    end
  endtask

  task automatic test_long_turn();
    int t;
    int gaps[4] = '{1024, 1024, 1524, 1024};
    reset_dut();
    t = cyc + 20;
    add_pulse(t, 100, 1'b1);
    foreach (gaps[j]) begin t += gaps[j]; add_pulse(t, 100, 1'b1); end
    while (cyc < t + LAT + 60) begin
      step();
      want = expv(cyc);
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL long_turn cyc=%0d got=%h want=%h", cyc, got, want); end
    end
  endtask

  task automatic test_random();
    int t;
    reset_dut();
    dr_rand = 1'b1;
    t = cyc + 20;
    for (int j = 0; j < 6; j++) begin
      add_pulse(t, $urandom_range(200, D), 1'b1);
      t += $urandom_range(2000, 600);
    end
    while (cyc < ev[5] + LAT + 100) begin
      step();
      want = expv(cyc);
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, got, want); end
    end
  endtask

  task automatic test_skip();
    int t0, s1, ncr;
    reset_dut();
    t0 = cyc + 20;
    for (int j = 0; j < 3; j++) add_pulse(t0 + j * 1024, 100, 1'b1);
    s1 = t0 + 1024 + LAT;
    dr_s = s1 + 9 * 32;
    dr_e = s1 + 12 * 32;
    ncr = 0;
    while (cyc < t0 + 2048 + LAT + 50) begin
      step();
      want = expv(cyc);
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL skip cyc=%0d got=%h want=%h", cyc, got, want); end
      if (cyc >= s1 && cyc < s1 + 1024) ncr += int'(column_ready);
`ifdef SLICE_SEQ_STATS_EN
      if (cyc == s1 + 13 * 32) begin
        n_chk++;
        if (skip_cnt !== 16'd3) begin n_fail++; $display("FAIL skip_cnt got=%0d want=3", skip_cnt); end
      end
`endif
    end
    n_chk++;
    if (ncr != S * C - 3) begin n_fail++; $display("FAIL skip_count got=%0d want=%0d", ncr, S * C - 3); end
  endtask

  task automatic test_glitch();
    int t0;
    reset_dut();
    t0 = cyc + 20;
    for (int j = 0; j < 4; j++) add_pulse(t0 + j * 1024, 100, 1'b1);
    add_pulse(t0 + 1024 + 300, 10, 1'b0);
    add_pulse(t0 + 1024 + 600, D - 1, 1'b0);
    add_pulse(t0 + 2048 + 300, 100, 1'b0);
    while (cyc < t0 + 3072 + LAT + 100) begin
      step();
      want = expv(cyc);
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL glitch cyc=%0d got=%h want=%h", cyc, got, want); end
    end
`ifdef SLICE_SEQ_STATS_EN
    n_chk++;
    if (short_cnt !== 8'd1) begin n_fail++; $display("FAIL short_cnt got=%0d want=1", short_cnt); end
`endif
  endtask

  task automatic test_window();
    int f1, f2;
    reset_dut();
    f1 = cyc + 20 + MINP - 1;
    f2 = f1 + MINP;
    add_pulse(cyc + 20, 100, 1'b0);
    add_pulse(f1, 100, 1'b0);
    add_pulse(f2, 100, 1'b0);
    while (cyc < f2 + LAT + 5) begin
      step();
      if (cyc == f1 + LAT || cyc == f2 + LAT - 1) begin
        n_chk++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL window_short cyc=%0d locked=%b want 0", cyc, locked); end
      end
      if (cyc == f2 + LAT) begin
        n_chk++;
        if ({locked, position_sync, period} !== {2'b11, 16'(MINP)}) begin
          n_fail++;
          $display("FAIL window_min locked=%b sync=%b period=%0d want 1 1 %0d", locked, position_sync, period, MINP);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int t0, s1;
    reset_dut();
    t0 = cyc + 20;
    add_pulse(t0, 100, 1'b1);
    add_pulse(t0 + 1024, 100, 1'b1);
    s1 = t0 + 1024 + LAT;
    while (cyc < s1 + MAXP + 3) begin
      step();
      if (cyc == s1 + MAXP) begin
        n_chk++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL timeout_hold locked=%b want 1", locked); end
      end
      if (cyc == s1 + MAXP + 1) begin
        n_chk++;
        if (got[23:16] !== 8'h00) begin n_fail++; $display("FAIL timeout_drop got=%h want 00", got[23:16]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    reset_dut();
    t0 = cyc + 20;
    add_pulse(t0, 100, 1'b1);
    add_pulse(t0 + 1024, 100, 1'b1);
    while (cyc < t0 + 1024 + LAT + 4 * 128 + 50) begin
      step();
      want = expv(cyc);
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL pre_reset cyc=%0d got=%h want=%h", cyc, got, want); end
    end
    @(posedge clock_66);
    #3 nrst = 1'b0;
    #1;
    n_chk++;
    if ({locked, position_sync, column_ready, slice_idx, column_idx, period} !== 24'h0) begin
      n_fail++;
      $display("FAIL async_reset got=%h want 000000", {locked, position_sync, column_ready, slice_idx, column_idx, period});
    end
    reset_dut();
    t0 = cyc + 20;
    add_pulse(t0, 100, 1'b1);
    add_pulse(t0 + 1024, 100, 1'b1);
    while (cyc < t0 + 1024 + LAT + 40) begin
      step();
      want = expv(cyc);
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL relock cyc=%0d got=%h want=%h", cyc, got, want); end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_long_turn();
    test_random();
    test_skip();
    test_glitch();
    test_window();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/slice_sequencer.md
# slice_sequencer

Rotation-locked scheduler for the LED column datapath. Measures rotor period from the hall sensor and splits each turn into SLICES angular slices, each with COLUMNS column time-slots. Generates `position_sync` for driver_controller and `column_ready` for column_mux, both gated by driver readiness. Sits between the GPIO hall input and the driver_controller/column_mux pair; replaces their tied-high strobes.

## Interface
- SLICES, 128: slices per turn; power of two.
- COLUMNS, 8: column slots per slice; power of two; must equal column_mux width.
- PERIOD_W, 24: period counter width.
- MIN_PERIOD, 65536: shortest accepted turn, in cycles.
- MAX_PERIOD, 8_000_000: longest turn; saturation forces unlock.
- DEBOUNCE, 16: cycles `hall_n` must stay low to count as an edge.
- clock_66  in  1  66 MHz system clock.
- nrst  in  1  asynchronous, active-low reset.
- hall_n  in  1  raw hall sensor, asynchronous, active low.
- driver_ready  in  1  driver_controller can accept a new column.
- position_sync  out  1  one-cycle pulse at each slice start.
- column_ready  out  1  one-cycle pulse at each granted column slot.
- slice_idx  out  $clog2(SLICES)  current slice.
- column_idx  out  $clog2(COLUMNS)  current column slot.
- locked  out  1  rotation lock acquired; high only in RUN.
- period  out  PERIOD_W  last accepted turn length in cycles.

## Operation
- Hall input goes through a 2-flop synchronizer, then a filter. An edge is accepted once the synced level has been low for DEBOUNCE consecutive cycles after having been high. At most one edge per low phase.
- `turn_cnt` increments every cycle and clears on an accepted edge. It saturates at MAX_PERIOD.
- The FSM has three states: UNLOCKED, ACQUIRE, RUN.
  - UNLOCKED: on an accepted edge, clear `turn_cnt` and go to ACQUIRE.
  - ACQUIRE: on an edge with MIN_PERIOD ≤ `turn_cnt` < MAX_PERIOD, latch `period`, compute the slot lengths and go to RUN. On an edge with `turn_cnt` < MIN_PERIOD, stay in ACQUIRE and restart counting. On saturation, go to UNLOCKED.
  - RUN: an edge inside the valid window relatches `period` and restarts slice 0. An edge below MIN_PERIOD is ignored as a glitch. Saturation returns the FSM to UNLOCKED.
- Slot lengths:
  - `slice_len` = period >> log2(SLICES).
  - `col_len` = `slice_len` >> log2(COLUMNS).
  - Truncating shifts, no rounding; remainder cycles are absorbed at the end of the turn.
- In RUN, a column timer reloads with `col_len`-1 and counts down.
  - At zero, `column_idx` increments.
  - On wrap of `column_idx` to 0, `slice_idx` increments and `position_sync` pulses.
- `slice_idx` saturates at SLICES-1. It does not wrap; it holds until the next hall edge.
- Every slot start raises `column_ready` for one cycle if `driver_ready` is high in that cycle. Otherwise the slot is skipped: no pulse, and the index still advances.
- Simultaneous events: a hall edge in the same cycle as a timer expiry → the edge wins. `slice_idx`=0, `column_idx`=0, one `position_sync` pulse.
- Outside RUN, `position_sync` and `column_ready` are held 0.

## Timing
- Reset values:
  - `position_sync`, `column_ready`, `locked`: 0.
  - `slice_idx`, `column_idx`: 0.
  - `period`: 0.
  - FSM: UNLOCKED.
- Edge latency: 2 sync cycles + DEBOUNCE cycles to acceptance. `position_sync` and `column_ready` are asserted in the cycle after acceptance.
- `locked` rises in the cycle after the accepting edge. It falls in the cycle after `turn_cnt` reaches MAX_PERIOD.
- `period` and the slot lengths update the cycle after the edge. The slot in progress is cut; there is no pipeline hold.
- Reset mid-turn: all outputs return to reset values immediately (asynchronous). Relock needs two edges.

## Configuration
- `SLICE_SEQ_STATS_EN`
  - Defined: adds output `skip_cnt` [15:0]. It counts slots skipped because `driver_ready` was low, saturates at 0xFFFF and clears on each accepted edge. It also adds `short_cnt` [7:0], which counts rejected sub-MIN_PERIOD edges, saturates, and clears only on reset.
  - Undefined: neither port exists, and no counters are synthesized.

## Structure
- Package `slice_seq_pkg` holds:
  - the FSM state enum (UNLOCKED, ACQUIRE, RUN);
  - default SLICES, COLUMNS, PERIOD_W;
  - a function computing a shift from a power-of-two parameter.
- Sub-module `hall_filter` (synchronizer, debounce, edge pulse; parameter DEBOUNCE). The top holds the period counter, FSM and slot timers.

## Test plan
- Reset, then no hall edges for MAX_PERIOD+10 cycles → `locked`=0, no `position_sync`, all indices 0.
- Hall edges every 131072 cycles, `driver_ready`=1 → `locked` set after the 2nd edge, `period`=131072.
  - `position_sync` every 1024 cycles, 128 per turn.
  - `column_ready` every 128 cycles, 1024 per turn.
- Same stimulus, turn lengthened to 131072+500 → `slice_idx` holds at 127 for 500 cycles, then returns to 0 on the edge.
- Glitch: a 10-cycle low pulse on `hall_n` → no edge accepted. A second edge 1000 cycles after a valid edge, in RUN → ignored; with the macro defined, `short_cnt`=1.
- `driver_ready` forced 0 for 3 slots mid-slice → 3 missing `column_ready` pulses, and `column_idx` still advances by 3. With the macro defined, `skip_cnt`=3.
- `nrst` asserted mid-slice 40 → all outputs 0 in the same cycle. After release, relock needs two edges.
